repeat_range_scanner: RTL and testbench
=======================================

Name: repeat_range_scanner

Overview:
- Successor to the single-number digit/combination counter, generalised from one number to an inclusive ID range [lo, hi].
- Scans every integer in the range and flags IDs whose decimal digit string is a block repeated k times.
- Accumulates the sum and count of flagged IDs across ranges.
- Sits behind the puzzle-input parser; one range per valid/ready handshake.

Parameters:
- DATA_WIDTH, 40, width of range_lo/range_hi (binary IDs).
- MAX_DIGITS, 13, BCD digit capacity; must satisfy 10^MAX_DIGITS > 2^DATA_WIDTH-1.
- SUM_WIDTH, 64, width of sum_out.
- REPEAT_MODE, 0, 0 = exactly two repeats (k=2); 1 = any k>=2.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- range_valid  in  1  range_lo/range_hi valid.
- range_ready  out  1  block idle, can accept a range.
- range_lo  in  DATA_WIDTH  inclusive range start.
- range_hi  in  DATA_WIDTH  inclusive range end.
- clear_in  in  1  zero accumulators; honoured only while range_ready=1.
- sum_out  out  SUM_WIDTH  running sum of flagged IDs.
- count_out  out  32  running count of flagged IDs.
- sum_ovf  out  1  sticky; set when any sum addition carries out.
- done_pulse  out  1  one-cycle pulse after a range finishes.

Behaviour:
- Reset, asynchronous and active-low:
  - state=IDLE, range_ready=1.
  - sum_out=0, count_out=0, sum_ovf=0, done_pulse=0.
  - All internal BCD and binary registers cleared.
  - Reset mid-scan aborts the range; partial results are discarded.
- IDLE:
  - range_ready=1.
  - A handshake (range_valid & range_ready) latches lo and hi and moves to CONV.
  - clear_in zeros sum_out, count_out and sum_ovf.
  - Clear and handshake in the same cycle: clear applies first, and the new range accumulates from 0.
- CONV:
  - Double-dabble conversion of lo into a MAX_DIGITS BCD register: exactly DATA_WIDTH cycles, one shift per cycle.
  - Also computes ndig, the digit count of lo, with 0 counted as 1 digit.
  - If lo > hi, goes to DONE; otherwise goes to SCAN.
- SCAN (one ID per cycle):
  - cur_bin and cur_bcd advance together.
  - Flag test is combinational on cur_bcd and ndig, for each period p with p | ndig and p < ndig:
    - match_p = all digits i in [p, ndig) satisfy d[i] == d[i-p].
  - REPEAT_MODE 0: flag = (ndig even) & match_{ndig/2}.
  - REPEAT_MODE 1: flag = OR over all valid p.
  - ndig = 1 never flags.
  - On flag: sum_out += cur_bin, zero-extended, modulo 2^SUM_WIDTH; a carry-out sets sum_ovf; count_out += 1, saturating at all-ones.
  - If cur_bin == hi, goes to DONE. The comparison happens before the increment, so hi = 2^DATA_WIDTH-1 never wraps.
  - Otherwise cur_bin+1, BCD +1 with decimal carry. A carry into digit ndig increments ndig (999 -> 1000, ndig 3 -> 4).
- DONE:
  - One cycle; done_pulse=1; then returns to IDLE.
  - range_ready goes 1 in the cycle after DONE.
- Timing:
  - For N = hi-lo+1 (N = 0 if lo > hi), range_ready stays low for DATA_WIDTH + N + 1 cycles after the accept edge.
  - sum_out and count_out update on the clock edge ending each SCAN cycle.
- Inputs are ignored while range_ready=0, and clear_in is ignored while busy.

Optional Feature:
- Macro RSCAN_MATCH_STREAM_EN.
- Defined:
  - Adds ports match_valid (out, 1) and match_id (out, DATA_WIDTH).
  - Each flagged ID is presented for exactly the one SCAN cycle in which it is tested.
  - No backpressure.
  - Both ports reset to 0; match_id holds its last value when match_valid=0.
- Undefined: the ports and logic are absent. Behaviour is otherwise identical.

Test Plan:
- REPEAT_MODE 0, range 11..22 -> sum_out=33, count_out=2; done_pulse exactly DATA_WIDTH+12+1 cycles after accept.
- Range 95..115 -> REPEAT_MODE 0: sum 99, count 1; REPEAT_MODE 1: sum 210 (99+111), count 2.
- Range 998..1012 (crosses 3->4 digits) -> REPEAT_MODE 0: sum 1010; REPEAT_MODE 1: sum 2009 (999+1010).
- Back-to-back 11..22 then 95..115 in mode 0 -> sum 132, count 3. Then clear_in in IDLE -> 0/0. Then lo=50, hi=40 -> done_pulse after DATA_WIDTH+1 cycles, sum 0.
- Range 1..9, then 222220..222224 in mode 1 -> single digits flag none; only 222222 flags, sum 222222. Deassert reset_n mid-scan -> all outputs 0 asynchronously, range_ready=1 after release.
- With RSCAN_MATCH_STREAM_EN, range 1188511880..1188511890 in mode 0 -> match_valid high for exactly one cycle with match_id=1188511885.

Source files
------------

// File: rtl/repeat_range_scanner.sv
// Scans an inclusive ID range and accumulates the sum/count of IDs whose decimal form is a repeated
// block. Optional flagged-ID output stream enabled by the RSCAN_MATCH_STREAM_EN macro.
module repeat_range_scanner #(
  parameter int unsigned DATA_WIDTH  = 40,
  parameter int unsigned MAX_DIGITS  = 13,
  parameter int unsigned SUM_WIDTH   = 64,
  parameter int unsigned REPEAT_MODE = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  range_valid,
  output logic                  range_ready,
  input  logic [DATA_WIDTH-1:0] range_lo,
  input  logic [DATA_WIDTH-1:0] range_hi,
  input  logic                  clear_in,
  output logic [SUM_WIDTH-1:0]  sum_out,
  output logic [31:0]           count_out,
  output logic                  sum_ovf,
  output logic                  done_pulse
`ifdef RSCAN_MATCH_STREAM_EN
  ,
  output logic                  match_valid,
  output logic [DATA_WIDTH-1:0] match_id
`endif
);

  localparam int unsigned BcdW  = 4 * MAX_DIGITS;
  localparam int unsigned NdW   = $clog2(MAX_DIGITS + 1);
  localparam int unsigned CntW  = $clog2(DATA_WIDTH + 1);
  localparam int unsigned SumXW = SUM_WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StConv, StScan, StDone} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] cur_q, cur_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BcdW-1:0]       bcd_q, bcd_d;
  logic [NdW-1:0]        ndig_q, ndig_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [SUM_WIDTH-1:0]  sum_q, sum_d;
  logic [31:0]           count_q, count_d;
  logic                  ovf_q, ovf_d;

  logic [BcdW-1:0]       bcd_dabble;
  logic [BcdW-1:0]       bcd_inc;
  logic                  inc_carry;
  logic [MAX_DIGITS-1:0] match;
  logic                  flag;
  logic [SUM_WIDTH:0]    sum_add;

  // Index of the most significant non-zero digit plus one; zero still counts as one digit.
  function automatic logic [NdW-1:0] digit_count(input logic [BcdW-1:0] b);
    digit_count = NdW'(1);
    for (int i = 1; i < MAX_DIGITS; i++) begin
      if (b[4*i +: 4] != 4'd0) digit_count = NdW'(i + 1);
    end
  endfunction

  // One double-dabble step: add-3 correction then shift in the next binary MSB.
  always_comb begin
    bcd_dabble = bcd_q;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_dabble[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_dabble = {bcd_dabble[BcdW-2:0], shift_q[DATA_WIDTH-1]};
  end

  always_comb begin
    bcd_inc   = bcd_q;
    inc_carry = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (inc_carry) begin
        if (bcd_q[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
          inc_carry         = 1'b0;
        end
      end
    end
  end

  // match[p]: digits at and above p equal the digit p places below, within ndig digits.
  always_comb begin
    match    = '0;
    for (int p = 1; p < MAX_DIGITS; p++) begin
      match[p] = 1'b1;
      for (int i = p; i < MAX_DIGITS; i++) begin
        if (i < int'(ndig_q) && bcd_q[4*i +: 4] != bcd_q[4*(i-p) +: 4]) match[p] = 1'b0;
      end
    end
  end

  always_comb begin
    flag = 1'b0;
    if (REPEAT_MODE == 0) begin
      if (!ndig_q[0]) flag = match[ndig_q >> 1];
    end else begin
      for (int p = 1; p < MAX_DIGITS; p++) begin
        if (NdW'(p) < ndig_q && (ndig_q % NdW'(p)) == '0 && match[p]) flag = 1'b1;
      end
    end
  end

  assign sum_add = {1'b0, sum_q} + SumXW'(cur_q);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    hi_d    = hi_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    ndig_d  = ndig_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (clear_in) begin
          sum_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
        if (range_valid) begin
          cur_d   = range_lo;
          shift_d = range_lo;
          hi_d    = range_hi;
          bcd_d   = '0;
          ndig_d  = '0;
          cnt_d   = '0;
          state_d = StConv;
        end
      end
      StConv: begin
        bcd_d   = bcd_dabble;
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
          ndig_d  = digit_count(bcd_dabble);
          state_d = (cur_q > hi_q) ? StDone : StScan;
        end
      end
      StScan: begin
        if (flag) begin
          sum_d = sum_add[SUM_WIDTH-1:0];
          if (sum_add[SUM_WIDTH]) ovf_d = 1'b1;
          if (count_q != '1) count_d = count_q + 32'd1;
        end
        // Compare before incrementing so an all-ones hi never wraps.
        if (cur_q == hi_q) begin
          state_d = StDone;
        end else begin
          cur_d  = cur_q + DATA_WIDTH'(1);
          bcd_d  = bcd_inc;
          ndig_d = (digit_count(bcd_inc) > ndig_q) ? digit_count(bcd_inc) : ndig_q;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cur_q   <= '0;
      hi_q    <= '0;
      shift_q <= '0;
      bcd_q   <= '0;
      ndig_q  <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      hi_q    <= hi_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      ndig_q  <= ndig_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign range_ready = (state_q == StIdle);
  assign done_pulse  = (state_q == StDone);
  assign sum_out     = sum_q;
  assign count_out   = count_q;
  assign sum_ovf     = ovf_q;

`ifdef RSCAN_MATCH_STREAM_EN
  logic [DATA_WIDTH-1:0] last_id_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_id_q <= '0;
    end else if (match_valid) begin
      last_id_q <= cur_q;
    end
  end

  assign match_valid = (state_q == StScan) && flag;
  assign match_id    = match_valid ? cur_q : last_id_q;
`endif

endmodule

// File: tb/tb_repeat_range_scanner.sv
// Self-checking bench: two scanners (exact-two and any-k repeat modes) share stimulus; a decimal
// string model fills a scoreboard that is drained when each range completes.
module tb_repeat_range_scanner;

  localparam int DW = 40;
  localparam int MD = 13;
  localparam int SW = 64;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          range_valid = 1'b0;
  logic [DW-1:0] range_lo = '0;
  logic [DW-1:0] range_hi = '0;
  logic          clear_in = 1'b0;

  logic          ready0, ready1, ovf0, ovf1, done0, done1;
  logic [SW-1:0] sum0, sum1;
  logic [31:0]   count0, count1;
`ifdef RSCAN_MATCH_STREAM_EN
  logic          mv0, mv1;
  logic [DW-1:0] mid0, mid1;
`endif

  always #5 clock = ~clock;

  repeat_range_scanner #(.DATA_WIDTH(DW), .MAX_DIGITS(MD), .SUM_WIDTH(SW), .REPEAT_MODE(0)) u_m0 (
    .clock       (clock),
    .reset_n     (reset_n),
    .range_valid (range_valid),
    .range_ready (ready0),
    .range_lo    (range_lo),
    .range_hi    (range_hi),
    .clear_in    (clear_in),
    .sum_out     (sum0),
    .count_out   (count0),
    .sum_ovf     (ovf0),
    .done_pulse  (done0)
`ifdef RSCAN_MATCH_STREAM_EN
    ,
    .match_valid (mv0),
    .match_id    (mid0)
`endif
  );

  repeat_range_scanner #(.DATA_WIDTH(DW), .MAX_DIGITS(MD), .SUM_WIDTH(SW), .REPEAT_MODE(1)) u_m1 (
    .clock       (clock),
    .reset_n     (reset_n),
    .range_valid (range_valid),
    .range_ready (ready1),
    .range_lo    (range_lo),
    .range_hi    (range_hi),
    .clear_in    (clear_in),
    .sum_out     (sum1),
    .count_out   (count1),
    .sum_ovf     (ovf1),
    .done_pulse  (done1)
`ifdef RSCAN_MATCH_STREAM_EN
    ,
    .match_valid (mv1),
    .match_id    (mid1)
`endif
  );

  typedef struct {
    longint unsigned sum0;
    longint unsigned cnt0;
    longint unsigned sum1;
    longint unsigned cnt1;
    int              cycles;
  } exp_t;

  exp_t            sb[$];
  longint unsigned m_sum0 = 0, m_cnt0 = 0, m_sum1 = 0, m_cnt1 = 0;
  int              n_tests = 0;
  int              n_fail = 0;

`ifdef RSCAN_MATCH_STREAM_EN
  int              mcnt0 = 0, mcnt1 = 0;
  logic [DW-1:0]   mlast0 = '0, mlast1 = '0;
  always @(negedge clock) begin
    if (mv0) begin mcnt0++; mlast0 = mid0; end
    if (mv1) begin mcnt1++; mlast1 = mid1; end
  end
`endif

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Decimal repeat test straight from the digit string.
  function automatic bit is_rep(input longint unsigned v, input int mode);
    int              d[20];
    int              n;
    longint unsigned t;
    bit              ok;
    n = 0;
    t = v;
    do begin
      d[n] = int'(t % 10);
      t    = t / 10;
      n++;
    end while (t != 0);
    for (int p = 1; p < n; p++) begin
      if (n % p == 0 && (mode == 1 || 2 * p == n)) begin
        ok = 1'b1;
        for (int i = p; i < n; i++) if (d[i] != d[i-p]) ok = 1'b0;
        if (ok) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic check_totals(input string tag, input exp_t e);
    check_eq({tag, ".sum0"}, sum0, e.sum0);
    check_eq({tag, ".cnt0"}, count0, e.cnt0);
    check_eq({tag, ".sum1"}, sum1, e.sum1);
    check_eq({tag, ".cnt1"}, count1, e.cnt1);
    check_eq({tag, ".ovf"}, {ovf1, ovf0}, 2'b00);
  endtask

  task automatic run_range(input string tag, input longint unsigned lo, input longint unsigned hi,
                           input bit poke);
    exp_t e;
    int   cyc;
    if (lo <= hi) begin
      for (longint unsigned v = lo; v <= hi; v++) begin
        if (is_rep(v, 0)) begin m_sum0 += v; m_cnt0++; end
        if (is_rep(v, 1)) begin m_sum1 += v; m_cnt1++; end
      end
    end
    e.sum0   = m_sum0;
    e.cnt0   = m_cnt0;
    e.sum1   = m_sum1;
    e.cnt1   = m_cnt1;
    e.cycles = DW + ((lo <= hi) ? int'(hi - lo + 1) : 0) + 1;
    sb.push_back(e);

    @(negedge clock);
    range_lo    = DW'(lo);
    range_hi    = DW'(hi);
    range_valid = 1'b1;
    @(posedge clock);
    #1;
    range_valid = 1'b0;
    cyc = 1;
    while (!done0 && cyc < e.cycles + 20) begin
      // Busy-time clear and a spurious request must both be ignored.
      if (poke) begin
        clear_in    = (cyc == 10);
        range_valid = (cyc == 10);
      end
      @(posedge clock);
      #1;
      cyc++;
    end
    clear_in    = 1'b0;
    range_valid = 1'b0;
    e = sb.pop_front();
    check_eq({tag, ".cycles"}, 64'(cyc), 64'(e.cycles));
    check_eq({tag, ".done1"}, done1, 1'b1);
    check_eq({tag, ".ready_in_done"}, {ready1, ready0}, 2'b00);
    check_totals(tag, e);
    @(posedge clock);
    #1;
    check_eq({tag, ".ready_after"}, {ready1, ready0}, 2'b11);
    check_eq({tag, ".done_after"}, {done1, done0}, 2'b00);
  endtask

  task automatic do_clear(input string tag);
    exp_t e;
    @(negedge clock);
    clear_in = 1'b1;
    @(negedge clock);
    clear_in = 1'b0;
    m_sum0   = 0;
    m_cnt0   = 0;
    m_sum1   = 0;
    m_cnt1   = 0;
    e        = '{0, 0, 0, 0, 0};
    check_totals(tag, e);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t z;
    z = '{0, 0, 0, 0, 0};
    #12;
    check_totals("reset", z);
    check_eq("reset.ready", {ready1, ready0}, 2'b11);
    check_eq("reset.done", {done1, done0}, 2'b00);
    @(negedge clock);
    reset_n = 1'b1;

    run_range("r11_22", 11, 22, 1'b0);
    run_range("r95_115", 95, 115, 1'b0);
    do_clear("clear1");
    run_range("r50_40", 50, 40, 1'b0);
    run_range("r998_1012", 998, 1012, 1'b0);
    do_clear("clear2");
    run_range("r1_9", 1, 9, 1'b0);
    run_range("r222220", 222220, 222224, 1'b0);
    run_range("rmax", 64'd1099511627773, 64'd1099511627775, 1'b0);
    do_clear("clear3");
`ifdef RSCAN_MATCH_STREAM_EN
    mcnt0 = 0;
    mcnt1 = 0;
`endif
    run_range("rstream", 64'd1188511880, 64'd1188511890, 1'b1);
`ifdef RSCAN_MATCH_STREAM_EN
    check_eq("stream.cnt0", 64'(mcnt0), 64'd1);
    check_eq("stream.id0", mlast0, 40'd1188511885);
    check_eq("stream.cnt1", 64'(mcnt1), 64'd1);
    check_eq("stream.hold0", mid0, 40'd1188511885);
`endif

    // Abort a long scan with an asynchronous reset in the middle of a clock phase.
    @(negedge clock);
    range_lo    = DW'(1);
    range_hi    = DW'(5000);
    range_valid = 1'b1;
    @(negedge clock);
    range_valid = 1'b0;
    repeat (70) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_totals("abort", z);
    check_eq("abort.ready", {ready1, ready0}, 2'b11);
    check_eq("abort.done", {done1, done0}, 2'b00);
`ifdef RSCAN_MATCH_STREAM_EN
    check_eq("abort.stream", {mv0, mid0}, 41'd0);
`endif
    m_sum0 = 0;
    m_cnt0 = 0;
    m_sum1 = 0;
    m_cnt1 = 0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check_eq("abort.ready_rel", {ready1, ready0}, 2'b11);
    run_range("post_abort", 11, 22, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
